mdu_hilo: RTL and testbench
===========================

Name: mdu_hilo

Overview:
- Multiply/divide unit in the E stage of the 5-stage MIPS pipeline.
- Produces the HI/LO values that the W-stage writeback select later reads for mfhi/mflo.
- Executes mult/multu/div/divu with fixed multi-cycle latency, and mthi/mtlo in a single cycle.
- Exposes busy so the hazard unit stalls D-stage md/mfhi/mflo instructions while an operation is in flight.

Parameters:
- MULT_CYCLES, 5, cycles busy stays high for mult/multu.
- DIV_CYCLES, 10, cycles busy stays high for div/divu.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  E-stage instruction is a md op; sampled on the rising edge
- md_op  input  3  operation: MULT, MULTU, DIV, DIVU, MTHI, MTLO
- A  input  32  rs value after forwarding (dividend / multiplicand / mthi-mtlo data)
- B  input  32  rt value after forwarding (divisor / multiplier)
- busy  output  1  a multi-cycle operation is in flight
- HI  output  32  architectural HI register
- LO  output  32  architectural LO register

Behaviour:
- Reset: synchronous, active-high. On a reset edge, HI=0, LO=0, busy=0 and counter=0. Any in-flight result is discarded. Reset takes priority over every other input.
- States: IDLE (counter==0, busy=0) and RUN (counter!=0, busy=1). busy is registered and equals (counter!=0).
- IDLE + start + MULT/MULTU: latch A and B and compute the 64-bit product.
  - MULT is signed; MULTU is unsigned.
  - Load counter=MULT_CYCLES. busy=1 from the next cycle.
- IDLE + start + DIV/DIVU: latch operands. Load counter=DIV_CYCLES.
  - DIV is signed: quotient truncates toward zero; the remainder takes the dividend's sign.
  - DIVU is unsigned.
- IDLE + start + MTHI: HI<=A at this edge, visible next cycle. busy stays 0; LO unchanged.
- IDLE + start + MTLO: LO<=A at this edge, visible next cycle. busy stays 0; HI unchanged.
- RUN: counter decrements every edge. On the edge where counter==1:
  - mult: HI<=product[63:32], LO<=product[31:0].
  - div: LO<=quotient, HI<=remainder.
  - counter becomes 0 and busy falls.
- Timing: start sampled at edge 0, so busy is high for exactly N cycles (cycles 1..N). New HI/LO are visible in cycle N+1, in the same cycle busy reads 0.
- HI/LO keep their old values throughout RUN.
- start while busy: ignored, no state change. The hazard unit must stall such instructions; the bench checks that they are ignored.
- Divide by zero (B==0) for DIV/DIVU: full busy period runs; HI and LO are NOT updated.
- DIV with 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No trap.
- Operands are latched at start. Changes on A/B during RUN have no effect.
- md_op values outside the six defined codes are ignored, even with start=1.
- Only state-holding elements: counter, busy, HI, LO, pending HI/LO (or latched operands and op).

Decomposition:
- Shared define header holds:
  - md_op encodings: MD_MULT=3'd0, MD_MULTU=3'd1, MD_DIV=3'd2, MD_DIVU=3'd3, MD_MTHI=3'd4, MD_MTLO=3'd5.
  - Default latency constants.
- The main decoder gains start/md_op outputs that drive this block.
- No sub-module is required. Arithmetic is inline, computed at start into pending registers, with a single counter FSM in the same module.

Test Plan:
- Reset then idle: assert reset for 2 cycles mid-run (DIV started 3 cycles earlier) -> busy=0, HI=0, LO=0 next cycle; old result never appears.
- MULT A=0xFFFFFFFE (-2), B=3 -> busy high cycles 1-5; cycle 6: HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV A=0xFFFFFFF9 (-7), B=2 -> busy cycles 1-10; cycle 11: LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU A=7, B=2 -> LO=3, HI=1.
- DIV by zero with HI=0x11111111, LO=0x22222222 preloaded via MTHI/MTLO -> busy 10 cycles; HI/LO unchanged afterwards.
- Start MULT A=2, B=2, then during busy pulse start with MTHI A=0xDEADBEEF and change A/B -> after completion HI=0, LO=4; MTHI had no effect.
- MTHI A=0x12345678 then MTLO A=0x9ABCDEF0 on consecutive cycles -> busy stays 0; HI and LO each update the cycle after their start edge.

Source files
------------

// File: rtl/mdu_hilo_pkg.sv
// mdu_hilo_pkg: shared definitions for the multiply/divide unit.
//   - md_op encodings driven by the main decoder
//   - default fixed latencies for mult/div
//   - FSM state type and HI/LO pair struct
//   - small arithmetic helper used by the signed divide path
package mdu_hilo_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // Wide enough for any sensible latency setting.
    localparam int CNT_W = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_t;

    // Magnitude of a two's complement word. 0x80000000 maps to itself,
    // which read as unsigned is the correct magnitude 2^31.
    function automatic logic [31:0] mag32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mdu_hilo_if.sv
// mdu_hilo_if: E-stage request / HI-LO response bundle of the MDU.
//   start  - E-stage instruction is a md op
//   md_op  - operation code (mdu_hilo_pkg::md_op_e)
//   A, B   - forwarded rs / rt values
//   busy   - multi-cycle operation in flight (to hazard unit)
//   HI, LO - architectural HI/LO (to W-stage writeback select)
// master: pipeline side, slave: the MDU itself.
interface mdu_hilo_if;

    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output start, md_op, A, B,
        input  busy, HI, LO
    );

    modport slave (
        input  start, md_op, A, B,
        output busy, HI, LO
    );

endinterface

// File: rtl/mdu_hilo.sv
// mdu_hilo: MIPS E-stage multiply/divide unit with HI/LO registers.
//   clk   - system clock, rising edge
//   reset - synchronous, active-high
//   bus   - mdu_hilo_if.slave (start/md_op/A/B in, busy/HI/LO out)
// The result is computed in the start cycle and parked in a pending
// register; a down-counter then models the fixed latency and commits the
// pending value to HI/LO on its final edge. busy is the registered FSM
// state and is high exactly while the counter is non-zero.
module mdu_hilo
    import mdu_hilo_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic      clk,
    input  logic      reset,
    mdu_hilo_if.slave bus
);

    mdu_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    hilo_t            hilo_q;
    hilo_t            pend_q;

    // Arithmetic on the live operands; only used in the start cycle.
    logic        op_signed;
    logic [63:0] mul_a, mul_b, prod;
    logic        div_zero;
    logic [31:0] dvd_mag, dvs_mag, uq, ur;
    logic        q_neg, r_neg;
    hilo_t       mul_res, div_res;

    always_comb begin
        op_signed = (bus.md_op == MD_MULT) || (bus.md_op == MD_DIV);

        // Sign/zero extend to 64 bits; the low 64 bits of the product are
        // then correct for both signed and unsigned operands.
        mul_a = op_signed ? {{32{bus.A[31]}}, bus.A} : {32'd0, bus.A};
        mul_b = op_signed ? {{32{bus.B[31]}}, bus.B} : {32'd0, bus.B};
        prod  = mul_a * mul_b;
        mul_res.hi = prod[63:32];
        mul_res.lo = prod[31:0];

        // Signed divide via magnitudes: quotient truncates toward zero,
        // remainder follows the dividend. INT_MIN / -1 falls out as
        // quotient 0x80000000, remainder 0 with no special case.
        div_zero = (bus.B == 32'd0);
        dvd_mag  = op_signed ? mag32(bus.A) : bus.A;
        dvs_mag  = op_signed ? mag32(bus.B) : bus.B;
        if (div_zero) begin
            dvs_mag = 32'd1;  // keep the divider well-defined; result unused
        end
        uq    = dvd_mag / dvs_mag;
        ur    = dvd_mag % dvs_mag;
        q_neg = op_signed && (bus.A[31] ^ bus.B[31]);
        r_neg = op_signed && bus.A[31];
        div_res.lo = q_neg ? (~uq + 32'd1) : uq;
        div_res.hi = r_neg ? (~ur + 32'd1) : ur;

        // Divide by zero commits the current HI/LO back, i.e. no change.
        // Nothing can write HI/LO during RUN, so this is exact.
        if (div_zero) begin
            div_res = hilo_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hilo_q  <= '0;
            pend_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        case (bus.md_op)
                            MD_MULT, MD_MULTU: begin
                                pend_q  <= mul_res;
                                cnt_q   <= CNT_W'(MULT_CYCLES);
                                state_q <= ST_RUN;
                            end
                            MD_DIV, MD_DIVU: begin
                                pend_q  <= div_res;
                                cnt_q   <= CNT_W'(DIV_CYCLES);
                                state_q <= ST_RUN;
                            end
                            MD_MTHI: hilo_q.hi <= bus.A;
                            MD_MTLO: hilo_q.lo <= bus.A;
                            default: ;  // undefined codes are ignored
                        endcase
                    end
                end
                ST_RUN: begin
                    // start is ignored here; the hazard unit stalls it.
                    if (cnt_q == CNT_W'(1)) begin
                        hilo_q  <= pend_q;
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy = (state_q == ST_RUN);
    assign bus.HI   = hilo_q.hi;
    assign bus.LO   = hilo_q.lo;

endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: directed-vector bench for mdu_hilo. Inputs are driven 1ns
// after the rising edge and outputs are sampled there too.
module tb_mdu_hilo;
    import mdu_hilo_pkg::*;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    mdu_hilo_if bus ();

    mdu_hilo #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one md op for a single edge (edge 0), then drop start.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.md_op = op;
        bus.A     = a;
        bus.B     = b;
        tick();
        bus.start = 1'b0;
    endtask

    // Count busy cycles after the start edge (bounded), scrambling A/B
    // while busy to show operands were latched; HI/LO must hold old values.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int n_busy,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        logic [31:0] old_hi, old_lo;
        int cnt;
        old_hi = bus.HI;
        old_lo = bus.LO;
        issue(op, a, b);
        cnt = 0;
        while (bus.busy && cnt < 50) begin
            if (cnt == 0) begin
                chk({tag, "_hold_hi"}, bus.HI, old_hi);
                chk({tag, "_hold_lo"}, bus.LO, old_lo);
            end
            cnt++;
            bus.A = $urandom;
            bus.B = $urandom;
            tick();
        end
        chk({tag, "_busy_cyc"}, 32'(cnt), 32'(n_busy));
        chk({tag, "_hi"}, bus.HI, exp_hi);
        chk({tag, "_lo"}, bus.LO, exp_lo);
    endtask

    initial begin
        int cnt;
        n_vec     = 0;
        n_err     = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.md_op = 3'd0;
        bus.A     = '0;
        bus.B     = '0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_hi", bus.HI, 32'h0);
        chk("rst_lo", bus.LO, 32'h0);

        // mthi then mtlo back to back, single-cycle each
        issue(MD_MTHI, 32'h12345678, 32'h0);
        chk("mthi_busy", 32'(bus.busy), 32'd0);
        chk("mthi_hi", bus.HI, 32'h12345678);
        chk("mthi_lo", bus.LO, 32'h0);
        issue(MD_MTLO, 32'h9ABCDEF0, 32'h0);
        chk("mtlo_busy", 32'(bus.busy), 32'd0);
        chk("mtlo_hi", bus.HI, 32'h12345678);
        chk("mtlo_lo", bus.LO, 32'h9ABCDEF0);

        // undefined op codes do nothing
        issue(3'd6, 32'hCAFEF00D, 32'h1);
        issue(3'd7, 32'hCAFEF00D, 32'h1);
        chk("badop_busy", 32'(bus.busy), 32'd0);
        chk("badop_hi", bus.HI, 32'h12345678);
        chk("badop_lo", bus.LO, 32'h9ABCDEF0);

        run_op("mult",  MD_MULT,  32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
        run_op("multu", MD_MULTU, 32'hFFFFFFFE, 32'd3, 5, 32'h00000002, 32'hFFFFFFFA);
        run_op("div",   MD_DIV,   32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div_nd", MD_DIV,  32'd7, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD);
        run_op("divu",  MD_DIVU,  32'd7, 32'd2, 10, 32'h00000001, 32'h00000003);
        run_op("divu_big", MD_DIVU, 32'hFFFFFFFF, 32'h10, 10, 32'h0000000F, 32'h0FFFFFFF);
        run_op("div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 10, 32'h0, 32'h80000000);

        // divide by zero leaves preloaded HI/LO intact
        issue(MD_MTHI, 32'h11111111, 32'h0);
        issue(MD_MTLO, 32'h22222222, 32'h0);
        run_op("div0",  MD_DIV,  32'h00000005, 32'h0, 10, 32'h11111111, 32'h22222222);
        run_op("divu0", MD_DIVU, 32'hFFFFFFFF, 32'h0, 10, 32'h11111111, 32'h22222222);

        // start while busy is ignored; A/B changes during RUN are ignored
        issue(MD_MULT, 32'd2, 32'd2);
        cnt = 0;
        while (bus.busy && cnt < 50) begin
            cnt++;
            if (cnt == 3) chk("ign_hold_hi", bus.HI, 32'h11111111);
            if (cnt == 2) begin
                bus.start = 1'b1;
                bus.md_op = MD_MTHI;
                bus.A     = 32'hDEADBEEF;
                bus.B     = 32'h0;
            end else begin
                bus.start = 1'b0;
                bus.A     = 32'h00000077;
                bus.B     = 32'h00000055;
            end
            tick();
        end
        bus.start = 1'b0;
        chk("ign_busy_cyc", 32'(cnt), 32'd5);
        chk("ign_hi", bus.HI, 32'h0);
        chk("ign_lo", bus.LO, 32'h4);

        // reset mid-run: DIV started 3 cycles earlier, then 2 reset cycles
        issue(MD_MTHI, 32'hA5A5A5A5, 32'h0);
        issue(MD_MTLO, 32'h5A5A5A5A, 32'h0);
        issue(MD_DIVU, 32'd100, 32'd7);
        tick();
        tick();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("rrun_busy", 32'(bus.busy), 32'd0);
        chk("rrun_hi", bus.HI, 32'h0);
        chk("rrun_lo", bus.LO, 32'h0);
        repeat (12) tick();
        chk("rrun_late_busy", 32'(bus.busy), 32'd0);
        chk("rrun_late_hi", bus.HI, 32'h0);
        chk("rrun_late_lo", bus.LO, 32'h0);

        // unit works normally after a mid-run reset
        run_op("post_rst", MD_MULTU, 32'h00010000, 32'h00010000, 5, 32'h00000001, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
